// File: rtl/downsample_capture_ctrl_pkg.sv
// Shared types and frame-geometry helpers for the downsampler capture controller.
package downsample_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_CAPTURE,
    ST_FLUSH,
    ST_DONE
  } cap_state_e;

  localparam int PIX_PER_WORD = 4;
  localparam int DEF_COLS     = 400;
  localparam int DEF_ROWS     = 300;

  function automatic int frame_pixels(input int cols, input int rows);
    return cols * rows;
  endfunction

  function automatic int frame_words(input int cols, input int rows);
    return frame_pixels(cols, rows) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/downsample_capture_ctrl_if.sv
// Frame-buffer write port: one packed word and its address per req/ack handshake.
interface downsample_capture_ctrl_if #(
  parameter int ADDR_WIDTH = 16
) ();
  import downsample_capture_ctrl_pkg::*;

  logic                        mem_req;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [8*PIX_PER_WORD-1:0]   mem_wdata;
  logic                        mem_ack;

  modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
  modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);

endinterface

// File: rtl/downsample_capture_ctrl_word_fifo.sv
// Synchronous {addr, data} word FIFO; pointers carry a wrap bit to tell full from empty.
module capture_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clock) begin
    if (push) store[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign dout  = store[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/downsample_capture_ctrl.sv
// Arms on start, captures one frame after frame_sync, packs 4 pixels per word and
// drains the words to the frame buffer through a small FIFO.
module downsample_capture_ctrl
  import downsample_capture_ctrl_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      frame_sync,
  input  logic                      pix_valid,
  input  logic                      pix_blank,
  input  logic [7:0]                pix_data,
  downsample_capture_ctrl_if.master mem,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      short_frame
);

  localparam int FRAME_PIXELS = frame_pixels(COLS, ROWS);
  localparam int CNT_W        = $clog2(FRAME_PIXELS + 1);
  localparam int ENTRY_W      = ADDR_WIDTH + 8 * PIX_PER_WORD;

  cap_state_e             state, state_nxt;
  logic [CNT_W-1:0]       pix_cnt;
  logic [ADDR_WIDTH-1:0]  word_idx;
  logic [ADDR_WIDTH-1:0]  word_addr;
  logic [23:0]            pack_p0;
  logic [1:0]             lane;
  logic                   accept;
  logic                   word_done;
  logic                   last_pix;
  logic                   short_hit;
  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
  logic [ENTRY_W-1:0]     fifo_din, fifo_dout;

  // A sync inside CAPTURE aborts the frame, so the pixel riding on it is not taken.
  assign accept    = (state == ST_CAPTURE) && pix_valid && !pix_blank && !frame_sync;
  assign lane      = pix_cnt[1:0];
  assign word_done = accept && (lane == 2'd3);
  assign last_pix  = accept && (pix_cnt == CNT_W'(FRAME_PIXELS - 1));
  assign short_hit = (state == ST_CAPTURE) && frame_sync;
  assign word_addr = ADDR_WIDTH'(BASE_ADDR) + word_idx;

  assign fifo_pop  = mem.mem_req && mem.mem_ack;
  assign fifo_push = word_done && (!fifo_full || fifo_pop);
  assign drop      = word_done && fifo_full && !fifo_pop;
  assign fifo_din  = {word_addr, pix_data, pack_p0};

  // ---- state register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (start)                  state_nxt = ST_WAIT_SYNC;
      ST_WAIT_SYNC: if (frame_sync)             state_nxt = ST_CAPTURE;
      ST_CAPTURE:   if (short_hit || last_pix)  state_nxt = ST_FLUSH;
      ST_FLUSH:     if (fifo_empty)             state_nxt = ST_DONE;
      ST_DONE:                                  state_nxt = ST_IDLE;
      default:                                  state_nxt = ST_IDLE;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE);
    mem.mem_req   = !fifo_empty && (state != ST_IDLE);
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (mem.mem_req) begin
      mem.mem_addr  = fifo_dout[ENTRY_W-1:32];
      mem.mem_wdata = fifo_dout[31:0];
    end
  end

  // ---- lane packing: lanes 0..2 are held, lane 3 goes straight into the FIFO ----
  always_ff @(posedge clock) begin
    if (accept && (lane != 2'd3)) pack_p0[{lane, 3'b000} +: 8] <= pix_data;
  end

  // ---- pixel/word counters; word_idx also advances for dropped words ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt  <= '0;
      word_idx <= '0;
    end else if ((state == ST_WAIT_SYNC) && frame_sync) begin
      pix_cnt  <= '0;
      word_idx <= '0;
    end else if (accept) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
      if (word_done) word_idx <= word_idx + ADDR_WIDTH'(1);
    end
  end

  // ---- sticky error flags, cleared on arm ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      if (drop)      overflow    <= 1'b1;
      if (short_hit) short_frame <= 1'b1;
    end
  end

  capture_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
